// File: rtl/shout_buzzer_drv.sv
// shout_buzzer_drv
//   Turns burst requests from the shout generator into a complementary piezo
//   drive carrying a warbling square-wave tone. Each burst lasts at least
//   MIN_ON cycles after the last shout rising edge and is followed by a
//   TAIL_CYC release tail. Continuous ON+TAIL time is capped at MAX_ON, after
//   which a COOL_CYC cooldown is forced.
//
// Ports
//   clk_in     in   clock
//   reset_n    in   asynchronous reset, active low
//   enable     in   1 = bursts allowed; 0 = abort to idle (cooldown still runs)
//   shout      in   burst request, same clock domain
//   buzz_p     out  piezo drive +, registered
//   buzz_n     out  piezo drive -, registered, never high together with buzz_p
//   active     out  high while a burst (ON or TAIL) is in progress
//   overheat   out  high during the forced cooldown
//   burst_cnt  out  bursts started from idle, wraps 255 -> 0
module shout_buzzer_drv #(
    parameter int unsigned HP_W     = 16,
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned HP_START = 200,
    parameter int unsigned HP_END   = 100,
    parameter int unsigned HP_STEP  = 5,
    parameter int unsigned MIN_ON   = 4000,
    parameter int unsigned TAIL_CYC = 2000,
    parameter int unsigned MAX_ON   = 1000000,
    parameter int unsigned COOL_CYC = 500000
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       shout,
    output logic       buzz_p,
    output logic       buzz_n,
    output logic       active,
    output logic       overheat,
    output logic [7:0] burst_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_TAIL,
        S_COOL
    } state_t;

    localparam logic [HP_W-1:0]  HP_HI      = HP_W'(HP_START);
    localparam logic [HP_W-1:0]  HP_LO      = HP_W'(HP_END);
    localparam logic [HP_W-1:0]  HP_STEP_N  = HP_W'(HP_STEP);
    localparam logic [HP_W-1:0]  HP_ONE     = HP_W'(1);
    localparam logic [HP_W:0]    HP_STEP_X  = (HP_W+1)'(HP_STEP);
    localparam logic [HP_W:0]    HP_HI_X    = (HP_W+1)'(HP_START);
    localparam logic [HP_W:0]    DOWN_CLAMP = (HP_W+1)'(HP_END + HP_STEP);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(TAIL_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_ON - 1);
    localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOL_CYC - 1);

    state_t            state, state_nxt;
    logic              shout_q;
    logic              phase, phase_nxt;
    logic              dir_up, dir_up_nxt;
    logic [HP_W-1:0]   hp, hp_nxt;
    logic [HP_W-1:0]   hp_cnt, hp_cnt_nxt;
    logic [CNT_W-1:0]  min_cnt, min_cnt_nxt;
    logic [CNT_W-1:0]  tail_cnt, tail_cnt_nxt;
    logic [CNT_W-1:0]  on_time, on_time_nxt;
    logic [CNT_W-1:0]  cool_cnt, cool_cnt_nxt;
    logic [7:0]        burst_cnt_nxt;
    logic              rise;
    logic              tone_adv;
    logic              act_nxt;

    assign rise    = shout & ~shout_q;
    assign act_nxt = (state_nxt == S_ON) || (state_nxt == S_TAIL);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            shout_q   <= 1'b0;
            phase     <= 1'b0;
            dir_up    <= 1'b0;
            hp        <= HP_HI;
            hp_cnt    <= '0;
            min_cnt   <= '0;
            tail_cnt  <= '0;
            on_time   <= '0;
            cool_cnt  <= '0;
            burst_cnt <= '0;
            buzz_p    <= 1'b0;
            buzz_n    <= 1'b0;
            active    <= 1'b0;
            overheat  <= 1'b0;
        end else begin
            state     <= state_nxt;
            shout_q   <= shout;
            phase     <= phase_nxt;
            dir_up    <= dir_up_nxt;
            hp        <= hp_nxt;
            hp_cnt    <= hp_cnt_nxt;
            min_cnt   <= min_cnt_nxt;
            tail_cnt  <= tail_cnt_nxt;
            on_time   <= on_time_nxt;
            cool_cnt  <= cool_cnt_nxt;
            burst_cnt <= burst_cnt_nxt;
            // Outputs are registered from next-state values so the pads
            // follow the state with no extra cycle of latency.
            buzz_p    <= phase_nxt & act_nxt;
            buzz_n    <= ~phase_nxt & act_nxt;
            active    <= act_nxt;
            overheat  <= (state_nxt == S_COOL);
        end
    end

    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        dir_up_nxt    = dir_up;
        hp_nxt        = hp;
        hp_cnt_nxt    = hp_cnt;
        min_cnt_nxt   = min_cnt;
        tail_cnt_nxt  = tail_cnt;
        on_time_nxt   = on_time;
        cool_cnt_nxt  = cool_cnt;
        burst_cnt_nxt = burst_cnt;
        tone_adv      = 1'b0;

        case (state)
            S_COOL: begin
                if (cool_cnt == COOL_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    cool_cnt_nxt = cool_cnt + CNT_ONE;
                end
            end

            S_IDLE: begin
                if (rise && enable) begin
                    state_nxt     = S_ON;
                    phase_nxt     = 1'b1;
                    hp_nxt        = HP_HI;
                    dir_up_nxt    = 1'b0;
                    hp_cnt_nxt    = '0;
                    min_cnt_nxt   = '0;
                    on_time_nxt   = '0;
                    burst_cnt_nxt = burst_cnt + 8'd1;
                end
            end

            S_ON, S_TAIL: begin
                if (!enable) begin
                    state_nxt = S_IDLE;
                end else if (on_time == MAX_LAST) begin
                    state_nxt    = S_COOL;
                    cool_cnt_nxt = '0;
                end else begin
                    on_time_nxt = on_time + CNT_ONE;
                    tone_adv    = 1'b1;
                    if (rise) begin
                        state_nxt   = S_ON;
                        min_cnt_nxt = '0;
                    end else if (state == S_ON) begin
                        // min_cnt holds the ON cycles already completed, so
                        // reaching MIN_LAST here means MIN_ON cycles at this edge;
                        // it saturates there while shout is held.
                        if (!shout && (min_cnt == MIN_LAST)) begin
                            state_nxt    = S_TAIL;
                            tail_cnt_nxt = '0;
                        end else if (min_cnt != MIN_LAST) begin
                            min_cnt_nxt = min_cnt + CNT_ONE;
                        end
                    end else begin
                        if (tail_cnt == TAIL_LAST) begin
                            state_nxt = S_IDLE;
                        end else begin
                            tail_cnt_nxt = tail_cnt + CNT_ONE;
                        end
                    end
                end
            end

            default: state_nxt = S_IDLE;
        endcase

        if (tone_adv) begin
            if (hp_cnt == hp - HP_ONE) begin
                hp_cnt_nxt = '0;
                phase_nxt  = ~phase;
                // A 0->1 toggle completes a full period: step the warble.
                if (!phase) begin
                    if (!dir_up) begin
                        if ({1'b0, hp} <= DOWN_CLAMP) begin
                            hp_nxt     = HP_LO;
                            dir_up_nxt = 1'b1;
                        end else begin
                            hp_nxt = hp - HP_STEP_N;
                        end
                    end else begin
                        if (({1'b0, hp} + HP_STEP_X) >= HP_HI_X) begin
                            hp_nxt     = HP_HI;
                            dir_up_nxt = 1'b0;
                        end else begin
                            hp_nxt = hp + HP_STEP_N;
                        end
                    end
                end
            end else begin
                hp_cnt_nxt = hp_cnt + HP_ONE;
            end
        end
    end

endmodule
